// File: rtl/dmem_responder.sv
// dmem_responder: data-side memory responder for the single-cycle MIPS core.
// Word-addressed RAM with byte-lane stores, sign/zero-extended byte loads,
// and a small register page (IO_OUT, CYCLE, STORES, STATUS) selected by the
// upper address half. Loads are combinational; all state updates on clk_i.
module dmem_responder #(
  parameter int          AW      = 10,
  parameter logic [15:0] MMIO_HI = 16'hFFFF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic        mem_rd_i,
  input  logic        mem_wr_i,
  input  logic        byte_i,
  input  logic        sig_ctr_i,
  output logic [31:0] rdata_o,
  output logic [31:0] io_out_o,
  output logic        err_o
);

  localparam int DEPTH = 1 << AW;

  // Register page word offsets (addr[15:2])
  localparam logic [13:0] OFF_IO_OUT = 14'd0;
  localparam logic [13:0] OFF_CYCLE  = 14'd1;
  localparam logic [13:0] OFF_STORES = 14'd2;
  localparam logic [13:0] OFF_STATUS = 14'd3;

  logic [31:0] mem_q [DEPTH];

  logic [31:0] io_out_q, io_out_d;
  logic [31:0] cycle_q,  cycle_d;
  logic [31:0] stores_q, stores_d;
  logic        err_q,    err_d;

  logic          sel_mmio;
  logic          sel_ram;
  logic          misalign;
  logic          illegal;
  logic          legal_wr;
  logic [1:0]    lane;
  logic [13:0]   reg_off;
  logic [AW-1:0] ram_idx;
  logic [31:0]   ram_word;
  logic [31:0]   reg_word;
  logic [31:0]   src_word;
  logic [7:0]    lane_byte;
  logic [31:0]   load_val;
  logic [31:0]   ram_merge;
  logic [31:0]   io_merge;
  logic          ram_we;
  logic          io_we;
  logic          stat_clr;

  // ---------------------------------------------------------------------
  // Address decode and access legality
  // ---------------------------------------------------------------------
  assign lane     = addr_i[1:0];
  assign reg_off  = addr_i[15:2];
  assign ram_idx  = addr_i[AW+1:2];
  // Register page takes priority should a parameter choice ever overlap RAM.
  assign sel_mmio = (addr_i[31:16] == MMIO_HI);
  assign sel_ram  = !sel_mmio && (addr_i[31:AW+2] == '0);
  assign misalign = !byte_i && (lane != 2'b00);
  assign illegal  = (mem_rd_i || mem_wr_i) && ((!sel_mmio && !sel_ram) || misalign);
  assign legal_wr = mem_wr_i && !illegal;

  // ---------------------------------------------------------------------
  // Load path
  // ---------------------------------------------------------------------
  assign ram_word = mem_q[ram_idx];

  // Register page read mux; unmapped offsets read as zero
  always_comb begin
    reg_word = 32'h0;
    case (reg_off)
      OFF_IO_OUT: reg_word = io_out_q;
      OFF_CYCLE:  reg_word = cycle_q;
      OFF_STORES: reg_word = stores_q;
      OFF_STATUS: reg_word = {31'h0, err_q};
      default:    reg_word = 32'h0;
    endcase
  end

  assign src_word = sel_mmio ? reg_word : ram_word;

  // Little-endian lane extraction from the selected source word
  always_comb begin
    lane_byte = 8'h0;
    case (lane)
      2'd0: lane_byte = src_word[7:0];
      2'd1: lane_byte = src_word[15:8];
      2'd2: lane_byte = src_word[23:16];
      2'd3: lane_byte = src_word[31:24];
      default: lane_byte = 8'h0;
    endcase
  end

  assign load_val = byte_i ? {{24{sig_ctr_i & lane_byte[7]}}, lane_byte} : src_word;
  assign rdata_o  = (mem_rd_i && !illegal) ? load_val : 32'h0;

  // ---------------------------------------------------------------------
  // Store path
  // ---------------------------------------------------------------------
  // Merge store data into an existing word: whole word, or one lane
  always_comb begin
    ram_merge = ram_word;
    io_merge  = io_out_q;
    if (!byte_i) begin
      ram_merge = wdata_i;
      io_merge  = wdata_i;
    end else begin
      case (lane)
        2'd0: begin ram_merge[7:0]   = wdata_i[7:0]; io_merge[7:0]   = wdata_i[7:0]; end
        2'd1: begin ram_merge[15:8]  = wdata_i[7:0]; io_merge[15:8]  = wdata_i[7:0]; end
        2'd2: begin ram_merge[23:16] = wdata_i[7:0]; io_merge[23:16] = wdata_i[7:0]; end
        2'd3: begin ram_merge[31:24] = wdata_i[7:0]; io_merge[31:24] = wdata_i[7:0]; end
        default: begin ram_merge = ram_word; io_merge = io_out_q; end
      endcase
    end
  end

  // RAM has no reset, so a store arriving while rst_i is high is blocked here.
  assign ram_we   = legal_wr && sel_ram && !rst_i;
  assign io_we    = legal_wr && sel_mmio && (reg_off == OFF_IO_OUT);
  // STATUS bit 0 lives in lane 0; a byte store to another lane cannot touch it.
  assign stat_clr = legal_wr && sel_mmio && (reg_off == OFF_STATUS) &&
                    wdata_i[0] && (!byte_i || (lane == 2'd0));

  // RAM write port
  always_ff @(posedge clk_i) begin
    if (ram_we) begin
      mem_q[ram_idx] <= ram_merge;
    end
  end

  // Next-state logic for the register page
  always_comb begin
    io_out_d = io_we ? io_merge : io_out_q;
    cycle_d  = cycle_q + 32'd1;
    stores_d = ram_we ? stores_q + 32'd1 : stores_q;
    // A new illegal access outranks a simultaneous clear.
    if (illegal) begin
      err_d = 1'b1;
    end else if (stat_clr) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end
  end

  // Register page state, cleared asynchronously by rst_i
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      io_out_q <= 32'h0;
      cycle_q  <= 32'h0;
      stores_q <= 32'h0;
      err_q    <= 1'b0;
    end else begin
      io_out_q <= io_out_d;
      cycle_q  <= cycle_d;
      stores_q <= stores_d;
      err_q    <= err_d;
    end
  end

  assign io_out_o = io_out_q;
  assign err_o    = err_q;

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-side memory responder for the single-cycle MIPS core: it sits at the far end of the core's data-memory interface (`MemRd`/`MemWr`/`byte`/`SigCtr`) and services loads and stores. It contains word-addressed RAM with byte-lane stores and sign- or zero-extended byte loads. It also exposes a small memory-mapped register page: an output port, a free-running cycle counter, a store counter and a sticky error status. Reads are same-cycle combinational so the core stays single-cycle; all state changes on the rising clock edge.

## Interface
- `AW`, default 10: RAM word-address width; RAM depth is 2^AW words.
- `MMIO_HI`, default 16'hFFFF: value of `addr[31:16]` that selects the register page.
- `clk`  in  1: system clock, rising edge.
- `rst`  in  1: reset, asynchronous and active-high.
- `addr`  in  32: byte address from the ALU result.
- `wdata`  in  32: store data; for byte stores, `wdata[7:0]` is used.
- `MemRd`  in  1: load request this cycle.
- `MemWr`  in  1: store request this cycle.
- `byte`  in  1: 1 = byte access, 0 = word access.
- `SigCtr`  in  1: byte loads only; 1 = sign-extend, 0 = zero-extend.
- `rdata`  out  32: load data, combinational.
- `io_out`  out  32: IO_OUT register.
- `err`  out  1: sticky access-error flag, equal to STATUS[0].

## Operation
- **Address decode**
  - MMIO when `addr[31:16]==MMIO_HI`.
  - RAM when `addr[31:AW+2]==0`.
  - Anything else is out-of-range.
- **Misaligned access**
  - Word access with `addr[1:0]!=0` is misaligned.
  - Byte access is never misaligned.
- **Illegal access**: out-of-range or misaligned, with `MemRd|MemWr` asserted.
  - Sets `err`.
  - Suppresses any write.
  - Forces `rdata=0`.
- **Byte lanes**: little-endian; `addr[1:0]=0` selects bits 7:0, and `=3` selects bits 31:24.
- **RAM load**
  - Word: `rdata = mem[addr[AW+1:2]]`.
  - Byte: the selected lane, extended to 32 bits per `SigCtr`.
- **RAM store**: at the edge, a word store replaces the whole word; a byte store replaces only the selected lane.
- **Registers**: byte offset `addr[15:0]`, with `addr[1:0]` taken as the byte lane.
  - 0x0 IO_OUT: read/write. Word and byte stores are both allowed; byte stores write one lane.
  - 0x4 CYCLE: read-only. Increments every clock while not in reset and wraps at 2^32.
  - 0x8 STORES: read-only. Increments on each accepted RAM store (word or byte) and wraps.
  - 0xC STATUS: bit0 = err, other bits read 0. A store with `wdata[0]=1` clears err.
  - Other offsets read 0; stores to them are ignored and are not errors.
  - Stores to CYCLE/STORES are ignored.
- **Byte loads from registers**: lane select plus extension, same as RAM.
- **`rdata`** is 0 whenever `MemRd=0`.
- **`MemRd` and `MemWr` both high**: `rdata` shows pre-edge contents, and the write lands at the edge.
- **err priority**: if an illegal access and a STATUS clear occur in the same cycle, set wins and err stays 1.
- **Reset values**: `io_out=0`, CYCLE=0, STORES=0, `err=0`, `rdata` follows inputs. RAM contents are not reset.

## Timing
- Load latency: 0 cycles; `rdata` is valid in the same cycle as `addr`/`MemRd`.
- Store latency: 1 edge; a load of the same address in the next cycle returns the new value.
- CYCLE holds 0 during `rst`.
  - At the first rising edge after `rst` falls it becomes 1.
  - A load in cycle k after release (before edge k+1) returns k.
- Asserting `rst` mid-operation immediately clears all registers and `err`.
  - A store in the reset cycle is dropped.
  - STORES does not count it.
- There is no backpressure and no wait states; every request completes in its cycle.

## Test plan
- **Word then byte store**: word store 0x11223344 to 0x10; byte store 0xAB to 0x12 → word load at 0x10 = 0x11AB3344, STORES=2.
- **Byte load extension**: RAM 0x4 = 0x000080FF, byte load at 0x4 → 0xFFFFFFFF (`SigCtr=1`) and 0x000000FF (`SigCtr=0`); byte load at 0x5 with `SigCtr=1` → 0xFFFFFF80.
- **Misaligned store**: word store to 0x6 → RAM unchanged, `err=1`, STORES unchanged; STATUS store of 1 → `err=0` next cycle; illegal load plus clear in the same cycle → `err` stays 1.
- **Out-of-range**: load at 0x0000_1000 with AW=10 → `rdata=0`, `err=1`.
- **Register page**: word store 0xDEADBEEF to 0xFFFF0000 → `io_out=0xDEADBEEF`; byte store 0x55 to 0xFFFF0003 → 0x55ADBEEF; store to 0xFFFF0004 ignored.
- **Reset**: release `rst`, load CYCLE in cycle 5 → 5; assert `rst` asynchronously mid-run → `io_out`, CYCLE, STORES and `err` all 0 before the next edge.
